// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between two pipeline stages: upstream valid/ready/data, downstream
// valid/ready/data, flush/exception controls and the back-pressure counter readout.
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_FIELDS = 7,
  parameter int unsigned CNT_W      = 16
);
  logic                         in_valid;
  logic                         in_ready;
  logic [NUM_FIELDS*DATA_W-1:0] in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [NUM_FIELDS*DATA_W-1:0] out_data;
  logic                         flush;
  logic                         req;
  logic [CNT_W-1:0]             stall_cnt;

  // Environment side: produces upstream bundles and consumes downstream ones.
  modport master (
    output in_valid, in_data, out_ready, flush, req,
    input  in_ready, out_valid, out_data, stall_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready, flush, req,
    output in_ready, out_valid, out_data, stall_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a two-entry skid buffer, flush-to-bubble, exception
// bubble carrying the handler PC, and a saturating back-pressure counter.
module pipe_stage_reg #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_FIELDS = 7,
  parameter int unsigned PC_IDX     = 1,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter int unsigned CNT_W      = 16
) (
  input logic             clk,
  input logic             reset,
  pipe_stage_reg_if.slave bus
);

  localparam int unsigned       BusW         = NUM_FIELDS * DATA_W;
  localparam logic [DATA_W-1:0] HandlerField = DATA_W'(HANDLER_PC);

  function automatic logic [BusW-1:0] handler_bubble();
    logic [BusW-1:0] b;
    b = '0;
    b[PC_IDX*DATA_W +: DATA_W] = HandlerField;
    return b;
  endfunction

  localparam logic [BusW-1:0] Bubble = handler_bubble();

  logic [BusW-1:0]  main_data_q, main_data_d;
  logic             main_valid_q, main_valid_d;
  logic [BusW-1:0]  skid_data_q, skid_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic in_ready;
  logic push;
  logic pop;

  // in_ready deliberately ignores out_ready so there is no comb path through the stage.
  assign in_ready = !skid_valid_q && !bus.req && !bus.flush;
  assign push     = bus.in_valid && in_ready;
  assign pop      = main_valid_q && bus.out_ready;

  always_comb begin
    main_data_d  = main_data_q;
    main_valid_d = main_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;

    if (bus.req) begin
      main_data_d  = Bubble;
      main_valid_d = 1'b1;
      skid_data_d  = '0;
      skid_valid_d = 1'b0;
    end else if (bus.flush) begin
      main_data_d  = '0;
      main_valid_d = 1'b0;
      skid_data_d  = '0;
      skid_valid_d = 1'b0;
    end else begin
      if (pop && skid_valid_q) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
      if (push && (!main_valid_q || pop)) begin
        main_data_d  = bus.in_data;
        main_valid_d = 1'b1;
      end else if (push) begin
        skid_data_d  = bus.in_data;
        skid_valid_d = 1'b1;
      end
      // Draining the last entry leaves the old data visible with valid low.
      if (pop && !push && !skid_valid_q) begin
        main_valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid_q && !bus.out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_data_q  <= '0;
      main_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      main_data_q  <= main_data_d;
      main_valid_q <= main_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = main_valid_q;
  assign bus.out_data  = main_data_q;
  assign bus.stall_cnt = stall_cnt_q;

  // The skid entry only ever fills behind an occupied main entry.
  skid_behind_main: assert property (@(posedge clk) disable iff (!reset)
    skid_valid_q |-> main_valid_q);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed plus randomized bench for pipe_stage_reg, checked against a FIFO-queue model.
module tb_pipe_stage_reg;

  localparam int unsigned DW  = 32;
  localparam int unsigned NF  = 7;
  localparam int unsigned PCI = 1;
  localparam int unsigned BW  = DW * NF;

  typedef logic [BW-1:0] bundle_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int total = 0;
  int bad   = 0;

  // Model: held bundles in arrival order, last value shown when empty, stall counts.
  bundle_t     q[$];
  bundle_t     last_out = '0;
  bundle_t     bubble;
  int unsigned cnt_a = 0;
  int unsigned cnt_b = 0;

  pipe_stage_reg_if #(.DATA_W(DW), .NUM_FIELDS(NF), .CNT_W(16)) bus_a ();
  pipe_stage_reg_if #(.DATA_W(DW), .NUM_FIELDS(NF), .CNT_W(3))  bus_b ();

  pipe_stage_reg #(
    .DATA_W(DW), .NUM_FIELDS(NF), .PC_IDX(PCI), .HANDLER_PC(32'h0000_4180), .CNT_W(16)
  ) dut_a (
    .clk(clk), .reset(rst_n), .bus(bus_a)
  );

  pipe_stage_reg #(
    .DATA_W(DW), .NUM_FIELDS(NF), .PC_IDX(PCI), .HANDLER_PC(32'h0000_4180), .CNT_W(3)
  ) dut_b (
    .clk(clk), .reset(rst_n), .bus(bus_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input bundle_t obs, input bundle_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bundle_t fld(input int k, input logic [DW-1:0] v);
    bundle_t b;
    b = '0;
    b[k*DW +: DW] = v;
    return b;
  endfunction

  function automatic bundle_t rnd_bundle();
    bundle_t b;
    for (int k = 0; k < NF; k++) b[k*DW +: DW] = $urandom;
    return b;
  endfunction

  function automatic bundle_t model_out();
    return (q.size() != 0) ? q[0] : last_out;
  endfunction

  task automatic model_reset();
    q.delete();
    last_out = '0;
    cnt_a    = 0;
    cnt_b    = 0;
  endtask

  task automatic drive(input logic iv, input bundle_t d, input logic ordy, input logic fl,
                       input logic rq);
    bus_a.in_valid = iv; bus_a.in_data = d; bus_a.out_ready = ordy;
    bus_a.flush = fl;    bus_a.req = rq;
    bus_b.in_valid = iv; bus_b.in_data = d; bus_b.out_ready = ordy;
    bus_b.flush = fl;    bus_b.req = rq;
  endtask

  task automatic check_all(input logic fl, input logic rq);
    logic rdy;
    rdy = (q.size() < 2) && !rq && !fl;
    chk("in_ready", bus_a.in_ready, rdy);
    chk("out_valid", bus_a.out_valid, q.size() != 0);
    chk("out_data", bus_a.out_data, model_out());
    chk("stall_cnt", bus_a.stall_cnt, cnt_a);
    chk("stall_cnt_w3", bus_b.stall_cnt, cnt_b);
  endtask

  // Starts at negedge+1; applies one cycle of inputs, checks, then updates the model.
  task automatic cycle(input logic iv, input bundle_t d, input logic ordy, input logic fl,
                       input logic rq);
    logic rdy, push, pop;
    drive(iv, d, ordy, fl, rq);
    #1;
    check_all(fl, rq);
    rdy  = (q.size() < 2) && !rq && !fl;
    push = iv && rdy;
    pop  = (q.size() != 0) && ordy;
    @(posedge clk);
    if ((q.size() != 0) && !ordy) begin
      if (cnt_a < 65535) cnt_a++;
      if (cnt_b < 7) cnt_b++;
    end
    if (rq) begin
      q.delete();
      q.push_back(bubble);
    end else if (fl) begin
      q.delete();
      last_out = '0;
    end else begin
      if (pop) last_out = q.pop_front();
      if (push) q.push_back(d);
    end
    @(negedge clk);
    drive(1'b0, '0, ordy, 1'b0, 1'b0);
    #1;
  endtask

  initial begin
    bundle_t a_b, b_b;
    bubble = fld(PCI, 32'h0000_4180);

    // Reset state
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    check_all(1'b0, 1'b0);
    chk("reset_out_data", bus_a.out_data, '0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    // Streaming at full throughput
    cycle(1'b1, fld(0, 32'h11), 1'b1, 1'b0, 1'b0);
    chk("stream_0x11", bus_a.out_data[DW-1:0], 32'h11);
    cycle(1'b1, fld(0, 32'h22), 1'b1, 1'b0, 1'b0);
    chk("stream_0x22", bus_a.out_data[DW-1:0], 32'h22);
    cycle(1'b1, fld(0, 32'h33), 1'b1, 1'b0, 1'b0);
    chk("stream_0x33", bus_a.out_data[DW-1:0], 32'h33);
    chk("stream_ready", bus_a.in_ready, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("stream_stall", bus_a.stall_cnt, 0);

    // Skid fill then drain
    a_b = fld(0, 32'hA);
    b_b = fld(0, 32'hB);
    cycle(1'b1, a_b, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, b_b, 1'b0, 1'b0, 1'b0);
    chk("skid_in_ready_low", bus_a.in_ready, 1'b0);
    chk("skid_head_a", bus_a.out_data, a_b);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("skid_then_b", bus_a.out_data, b_b);
    chk("skid_ready_back", bus_a.in_ready, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("skid_drained", bus_a.out_valid, 1'b0);

    // Exception bubble replaces two held bundles
    cycle(1'b1, fld(PCI, 32'h3000), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, fld(PCI, 32'h3004) | fld(0, 32'h5), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, fld(0, 32'h66), 1'b0, 1'b0, 1'b1);
    chk("req_valid", bus_a.out_valid, 1'b1);
    chk("req_bubble", bus_a.out_data, fld(1, 32'h0000_4180));
    chk("req_in_ready", bus_a.in_ready, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("req_bubble_held", bus_a.out_data, fld(1, 32'h0000_4180));
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("req_popped", bus_a.out_valid, 1'b0);

    // Flush with input offered
    cycle(1'b1, fld(0, 32'h41), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, fld(0, 32'h42), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, fld(0, 32'h77), 1'b0, 1'b1, 1'b0);
    chk("flush_valid", bus_a.out_valid, 1'b0);
    chk("flush_data", bus_a.out_data, '0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("flush_nothing_accepted", bus_a.out_valid, 1'b0);

    // Asynchronous reset mid-cycle with both entries full
    cycle(1'b1, fld(0, 32'h51), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, fld(0, 32'h52), 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("areset_valid", bus_a.out_valid, 1'b0);
    chk("areset_data", bus_a.out_data, '0);
    chk("areset_stall", bus_a.stall_cnt, 0);
    chk("areset_stall_w3", bus_b.stall_cnt, 0);
    chk("areset_in_ready", bus_a.in_ready, 1'b1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Back-pressure counter and saturation
    cycle(1'b1, fld(0, 32'h99), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("stall_five", bus_a.stall_cnt, 5);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("stall_ten", bus_a.stall_cnt, 10);
    chk("stall_sat_w3", bus_b.stall_cnt, 7);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("stall_after_flush", bus_a.stall_cnt, 11);
    chk("stall_sat_after_flush", bus_b.stall_cnt, 7);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, rnd_bundle(), $urandom_range(0, 2) != 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0);
    end
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check_all(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
